// File: rtl/if_fetch_if.sv
// Fetch-stage bus: pipeline control in, memory request/response, and the
// instruction presented to IF/ID.
interface if_fetch_if;
  logic        stall_in;
  logic        jump_in;
  logic [31:0] jump_addr_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;
  logic [31:0] pc_out;
  logic [31:0] instru_out;
  logic        valid_out;
  logic        stallfrom_if;

  // Fetch stage side.
  modport master (
    input  stall_in, jump_in, jump_addr_in, mem_done_in, mem_data_in,
    output mem_req_out, mem_addr_out, pc_out, instru_out, valid_out, stallfrom_if
  );

  // Environment side: stall/branch control, memory controller, IF/ID.
  modport slave (
    output stall_in, jump_in, jump_addr_in, mem_done_in, mem_data_in,
    input  mem_req_out, mem_addr_out, pc_out, instru_out, valid_out, stallfrom_if
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: fetch PC plus a direct-mapped one-word-per-line
// instruction cache. Misses issue a single word request to memory and stall
// the pipeline until the fill returns.
module if_fetch #(
  parameter int unsigned ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  if_fetch_if.master bus
);
  localparam int unsigned Entries = 2 ** ICACHE_IDX_W;
  localparam int unsigned TagW    = 30 - ICACHE_IDX_W;

  localparam logic [0:0] StLookup  = 1'b0;
  localparam logic [0:0] StWaitMem = 1'b1;

  logic [31:0]        pc_q, pc_d;
  logic [0:0]         state_q, state_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [Entries-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q [Entries];
  logic [31:0]        data_q [Entries];

  logic [ICACHE_IDX_W-1:0] idx, fill_idx;
  logic [TagW-1:0]         tag, fill_tag;
  logic                    hit, fill;
  logic [31:0]             jump_tgt;

  assign idx      = pc_q[ICACHE_IDX_W+1:2];
  assign tag      = pc_q[31:ICACHE_IDX_W+2];
  assign fill_idx = addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag = addr_q[31:ICACHE_IDX_W+2];
  assign jump_tgt = {bus.jump_addr_in[31:2], 2'b00};

  assign hit  = (state_q == StLookup) && valid_q[idx] && (tag_q[idx] == tag);
  assign fill = (state_q == StWaitMem) && bus.mem_done_in;

  // Outputs to IF/ID and stall control; all forced quiet while in reset.
  always_comb begin
    bus.valid_out    = hit && !rst_in;
    bus.instru_out   = (hit && !rst_in) ? data_q[idx] : 32'h0;
    bus.pc_out       = rst_in ? 32'h0 : pc_q;
    bus.stallfrom_if = !rst_in && !hit && !bus.jump_in;
    bus.mem_req_out  = req_q;
    bus.mem_addr_out = addr_q;
  end

  // Next-state: PC sequencing, miss handling and fill bookkeeping.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    case (state_q)
      StLookup: begin
        if (bus.jump_in) begin
          pc_d = jump_tgt;
        end else if (hit) begin
          if (!bus.stall_in) pc_d = pc_q + 32'd4;
        end else begin
          state_d = StWaitMem;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      StWaitMem: begin
        // The outstanding request always completes, even after a redirect.
        if (bus.mem_done_in) begin
          valid_d[fill_idx] = 1'b1;
          req_d             = 1'b0;
          state_d           = StLookup;
        end
        if (bus.jump_in) pc_d = jump_tgt;
      end
      default: state_d = StLookup;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q    <= RESET_PC;
      state_q <= StLookup;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data arrays need no reset; the valid bits gate them.
  always_ff @(posedge clk_in) begin
    if (fill && !rst_in) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data_in;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch: the bench plays memory controller, stall
// control and EX, and checks every cycle against an address-level model of
// the fetch stage (cache remembers full addresses, memory is a pure function).
module tb_if_fetch;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  if_fetch_if bus ();

  if_fetch #(
    .ICACHE_IDX_W(6),
    .RESET_PC    (32'h0)
  ) u_dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_busy;
  logic [31:0] m_req_addr;
  int          m_cnt;
  bit          m_valid [64];
  logic [31:0] m_addr  [64];
  int          lat_fix = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0513;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic rst, input logic stall, input logic jmp,
                       input logic [31:0] jaddr);
    bit hit;
    bit done;
    int i;
    @(negedge clk_in);
    done = !rst && m_busy && (m_cnt == 0);
    rst_in           = rst;
    bus.stall_in     = stall;
    bus.jump_in      = jmp;
    bus.jump_addr_in = jaddr;
    bus.mem_done_in  = done;
    bus.mem_data_in  = done ? mem_word(m_req_addr) : $urandom();
    #1;
    i   = idx_of(m_pc);
    hit = !m_busy && m_valid[i] && (m_addr[i] == m_pc);
    if (rst) begin
      check_eq("rst_valid", bus.valid_out, 32'h0);
      check_eq("rst_instr", bus.instru_out, 32'h0);
      check_eq("rst_pc", bus.pc_out, 32'h0);
      check_eq("rst_stall", bus.stallfrom_if, 32'h0);
    end else begin
      check_eq("valid", bus.valid_out, hit);
      check_eq("instr", bus.instru_out, hit ? mem_word(m_pc) : 32'h0);
      check_eq("pc", bus.pc_out, m_pc);
      check_eq("stallfrom_if", bus.stallfrom_if, !hit && !jmp);
    end
    check_eq("mem_req", bus.mem_req_out, m_busy);
    if (m_busy) check_eq("mem_addr", bus.mem_addr_out, m_req_addr);

    if (rst) begin
      m_pc   = 32'h0;
      m_busy = 0;
      foreach (m_valid[k]) m_valid[k] = 0;
    end else if (!m_busy) begin
      if (jmp) m_pc = jaddr & ~32'h3;
      else if (hit) begin
        if (!stall) m_pc = m_pc + 32'd4;
      end else begin
        m_busy     = 1;
        m_req_addr = m_pc;
        m_cnt      = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
    end else begin
      if (done) begin
        m_valid[idx_of(m_req_addr)] = 1;
        m_addr[idx_of(m_req_addr)]  = m_req_addr;
        m_busy = 0;
      end else begin
        m_cnt--;
      end
      if (jmp) m_pc = jaddr & ~32'h3;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0, 1:    t = 32'($urandom_range(0, 63)) << 2;
      2:       t = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      default: t = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
    endcase
    return t | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.stall_in     = 1'b0;
    bus.jump_in      = 1'b0;
    bus.jump_addr_in = 32'h0;
    bus.mem_done_in  = 1'b0;
    bus.mem_data_in  = 32'h0;
    m_pc   = 32'h0;
    m_busy = 0;
    foreach (m_valid[k]) m_valid[k] = 0;
    @(posedge clk_in);

    // Reset then cold start with fixed memory latency.
    lat_fix = 2;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    run(30);
    // Sequential hits from 0.
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    run(4);
    // Stall hold at 8.
    cycle(1'b0, 1'b0, 1'b1, 32'h8);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    run(2);
    // Redirect one cycle into a miss at 0x100.
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    run(1);
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    run(8);
    // Conflict eviction: 0x000 was displaced by 0x100.
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    run(8);
    // Reset mid-miss.
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    run(2);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    run(10);

    // Randomised traffic with variable latency.
    lat_fix = -1;
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, rand_target());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
